// File: rtl/maze_pkg.sv
// Shared types for the maze explorer: move directions, FSM states, grid size.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package maze_pkg;

  localparam int MAZE_DIM = 16;

  // Encoding doubles as probe priority: lower value is tried first.
  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PROBE,
    BACKTRACK,
    DONE,
    FAIL
  } state_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  // Unit step for one move.
  function automatic delta_t delta(input dir_t d);
    delta_t r;
    r.dx = 2'sb00;
    r.dy = 2'sb00;
    unique case (d)
      UP:      r.dy = 2'sb01;
      RIGHT:   r.dx = 2'sb01;
      LEFT:    r.dx = 2'sb11;
      DOWN:    r.dy = 2'sb11;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/maze_explorer_if.sv
// Bundles the maze memory port and the search/replay control signals.
// Latency: n/a (wiring only).
// Backpressure: replay is stalled by Run=0; memory port has no stall.
// Ports: X/Y/Rd/Wr/Din -> memory, Dout <- memory; Start/Run -> explorer;
//        Done/Fail/Move/MoveValid <- explorer.
interface maze_explorer_if;
  logic [3:0] X;
  logic [3:0] Y;
  logic       Rd;
  logic       Wr;
  logic       Din;
  logic       Dout;
  logic       Start;
  logic       Run;
  logic       Done;
  logic       Fail;
  logic [1:0] Move;
  logic       MoveValid;

  modport master (
    output X, Y, Rd, Wr, Din, Done, Fail, Move, MoveValid,
    input  Dout, Start, Run
  );

  modport slave (
    input  X, Y, Rd, Wr, Din, Done, Fail, Move, MoveValid,
    output Dout, Start, Run
  );
endinterface

// File: rtl/path_stack.sv
// 256x2 LIFO of moves holding the current route, plus a replay read port.
// Latency: push/pop take effect on the next edge; both read ports are combinational.
// Backpressure: none; the caller guarantees no push when full and no pop when empty.
// Ports: Clk/our_reset; clr empties; push/push_dat; pop/top_dat; sp depth;
//        rp/rd_dat replay read by index from the bottom.
module path_stack
  import maze_pkg::*;
(
  input  logic       Clk,
  input  logic       our_reset,
  input  logic       clr,
  input  logic       push,
  input  dir_t       push_dat,
  input  logic       pop,
  output dir_t       top_dat,
  output logic [8:0] sp,
  input  logic [7:0] rp,
  output dir_t       rd_dat
);

  dir_t       mem [256];
  logic [7:0] top_idx;

  always_ff @(posedge Clk or negedge our_reset) begin
    if (!our_reset) begin
      sp <= 9'd0;
    end else if (clr) begin
      sp <= 9'd0;
    end else if (push) begin
      sp <= sp + 9'd1;
    end else if (pop) begin
      sp <= sp - 9'd1;
    end
  end

  // Storage needs no reset: only entries below sp are ever read.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[sp[7:0]] <= push_dat;
    end
  end

  assign top_idx = sp[7:0] - 8'd1;
  assign top_dat = mem[top_idx];
  assign rd_dat  = mem[rp];

endmodule

// File: rtl/maze_explorer.sv
// Depth-first search over a 16x16 maze memory from (0,0) to the goal, then move replay.
// Latency: 1 cycle per probe or pop; Done/Fail and Move/MoveValid are registered (+1 cycle).
// Backpressure: Run=0 stalls replay without losing moves; the memory port never stalls.
// Ports: Clk, our_reset (async, active low); bus = maze_explorer_if.master
//        (memory X/Y/Rd/Wr/Din/Dout, control Start/Run, status Done/Fail/Move/MoveValid).
module maze_explorer
  import maze_pkg::*;
#(
  parameter int unsigned GOAL_X = 15,
  parameter int unsigned GOAL_Y = 15
) (
  input  logic            Clk,
  input  logic            our_reset,
  maze_explorer_if.master bus
);

  localparam logic [3:0] GX  = 4'(GOAL_X);
  localparam logic [3:0] GY  = 4'(GOAL_Y);
  localparam logic [5:0] DIM = 6'(MAZE_DIM);

  state_t     state;
  logic [3:0] cx, cy;
  dir_t       dir;
  logic [7:0] rp;

  logic [8:0] sp;
  dir_t       top_dat;
  dir_t       rd_dat;
  logic       push, pop, clr;

  delta_t     pd, bd;
  logic [5:0] cand_x, cand_y;
  logic       in_bounds;
  logic       at_goal;
  logic [3:0] back_x, back_y;

  // Candidate is computed 6 bits wide so a step off either edge lands
  // outside 0..15 (a step below zero wraps to 63).
  assign pd        = delta(dir);
  assign cand_x    = {2'b00, cx} + {{4{pd.dx[1]}}, pd.dx};
  assign cand_y    = {2'b00, cy} + {{4{pd.dy[1]}}, pd.dy};
  assign in_bounds = (cand_x < DIM) && (cand_y < DIM);
  assign at_goal   = (cand_x[3:0] == GX) && (cand_y[3:0] == GY);

  // Undo the move on top of the stack.
  assign bd     = delta(top_dat);
  assign back_x = cx - {{2{bd.dx[1]}}, bd.dx};
  assign back_y = cy - {{2{bd.dy[1]}}, bd.dy};

  // Memory port is combinational: the read and the marking write happen
  // in the same cycle, so each probe costs exactly one clock.
  always_comb begin
    bus.X  = cx;
    bus.Y  = cy;
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    unique case (state)
      INIT: begin
        bus.X  = 4'd0;
        bus.Y  = 4'd0;
        bus.Rd = 1'b1;
        bus.Wr = ~bus.Dout;
      end
      PROBE: begin
        if (in_bounds) begin
          bus.X  = cand_x[3:0];
          bus.Y  = cand_y[3:0];
          bus.Rd = 1'b1;
          bus.Wr = ~bus.Dout;
        end
      end
      default: ;
    endcase
  end

  assign bus.Din = bus.Wr;

  assign push = (state == PROBE) && bus.Wr;
  assign pop  = (state == BACKTRACK) && (sp != 9'd0);
  assign clr  = bus.Start && ((state == IDLE) || (state == DONE) || (state == FAIL));

  path_stack u_stack (
    .Clk      (Clk),
    .our_reset(our_reset),
    .clr      (clr),
    .push     (push),
    .push_dat (dir),
    .pop      (pop),
    .top_dat  (top_dat),
    .sp       (sp),
    .rp       (rp),
    .rd_dat   (rd_dat)
  );

  always_ff @(posedge Clk or negedge our_reset) begin
    if (!our_reset) begin
      state         <= IDLE;
      cx            <= 4'd0;
      cy            <= 4'd0;
      dir           <= UP;
      rp            <= 8'd0;
      bus.Done      <= 1'b0;
      bus.Fail      <= 1'b0;
      bus.Move      <= 2'b00;
      bus.MoveValid <= 1'b0;
    end else begin
      if (clr) begin
        cx       <= 4'd0;
        cy       <= 4'd0;
        dir      <= UP;
        rp       <= 8'd0;
        bus.Done <= 1'b0;
        bus.Fail <= 1'b0;
        state    <= INIT;
      end
      unique case (state)
        IDLE: ;
        INIT: begin
          if (bus.Dout) begin
            state    <= FAIL;
            bus.Fail <= 1'b1;
          end else begin
            state <= PROBE;
          end
        end
        PROBE: begin
          if (push) begin
            cx  <= cand_x[3:0];
            cy  <= cand_y[3:0];
            dir <= UP;
            if (at_goal) begin
              state    <= DONE;
              bus.Done <= 1'b1;
            end
          end else if (dir != DOWN) begin
            dir <= dir_t'(dir + 2'd1);
          end else begin
            state <= BACKTRACK;
          end
        end
        BACKTRACK: begin
          if (sp == 9'd0) begin
            state    <= FAIL;
            bus.Fail <= 1'b1;
          end else begin
            cx <= back_x;
            cy <= back_y;
            // A popped DOWN means every direction from the parent is spent.
            if (top_dat != DOWN) begin
              dir   <= dir_t'(top_dat + 2'd1);
              state <= PROBE;
            end
          end
        end
        DONE: begin
          bus.MoveValid <= 1'b0;
          if (!clr && bus.Run && ({1'b0, rp} < sp)) begin
            bus.MoveValid <= 1'b1;
            bus.Move      <= rd_dat;
            rp            <= rp + 8'd1;
          end
        end
        FAIL: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_explorer.sv
// Randomized and directed check of maze_explorer against a queue-based DFS model.
// Latency: n/a (testbench).
// Backpressure: Run is toggled randomly during replay.
module tb_maze_explorer;

  logic Clk = 1'b0;
  logic our_reset;
  logic load;

  always #5 Clk = ~Clk;

  maze_explorer_if bus ();

  maze_explorer #(.GOAL_X(15), .GOAL_Y(15)) dut (
    .Clk      (Clk),
    .our_reset(our_reset),
    .bus      (bus)
  );

  // Maze memory: image loaded on request, otherwise marked by the explorer.
  logic mem [16][16];
  logic img [16][16];
  int   wr_cnt;
  int   wr_addr [1024];
  int   din_bad;

  always @(posedge Clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          mem[i][j] <= img[i][j];
      wr_cnt  <= 0;
      din_bad <= 0;
    end else if (bus.Wr) begin
      mem[bus.X][bus.Y] <= 1'b1;
      if (wr_cnt < 1024) wr_addr[wr_cnt] <= int'(bus.X) * 16 + int'(bus.Y);
      wr_cnt <= wr_cnt + 1;
      if (!bus.Din) din_bad <= din_bad + 1;
    end
  end

  assign bus.Dout = bus.Rd ? mem[bus.X][bus.Y] : 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: textbook DFS with an explicit path queue.
  logic ref_mem [16][16];
  int   ref_wr[$];
  int   ref_path[$];
  bit   ref_ok;
  int   ref_cycles;

  function automatic int ddx(input int d);
    if (d == 1) return 1;
    if (d == 2) return -1;
    return 0;
  endfunction

  function automatic int ddy(input int d);
    if (d == 0) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  task automatic model_run();
    int x, y, d, nx, ny, probes, backs, pd;
    bit inb, free;
    ref_wr.delete();
    ref_path.delete();
    probes = 0;
    backs  = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        ref_mem[i][j] = img[i][j];
    if (ref_mem[0][0]) begin
      ref_ok     = 1'b0;
      ref_cycles = 2;
      return;
    end
    ref_mem[0][0] = 1'b1;
    ref_wr.push_back(0);
    x = 0; y = 0; d = 0;
    forever begin
      if (d < 4) begin
        probes++;
        nx = x + ddx(d);
        ny = y + ddy(d);
        inb  = (nx >= 0) && (nx < 16) && (ny >= 0) && (ny < 16);
        free = 1'b0;
        if (inb) free = !ref_mem[nx][ny];
        if (free) begin
          ref_mem[nx][ny] = 1'b1;
          ref_wr.push_back(nx * 16 + ny);
          ref_path.push_back(d);
          x = nx; y = ny; d = 0;
          if (x == 15 && y == 15) begin
            ref_ok = 1'b1;
            break;
          end
        end else begin
          d++;
        end
      end else begin
        backs++;
        if (ref_path.size() == 0) begin
          ref_ok = 1'b0;
          break;
        end
        pd = ref_path.pop_back();
        x = x - ddx(pd);
        y = y - ddy(pd);
        d = pd + 1;
      end
    end
    // INIT cycle + one per probe + one per backtrack + status visible next cycle.
    ref_cycles = probes + backs + 2;
  endtask

  task automatic replay(input string name);
    int idx, extra, c;
    bit prev, r;
    idx = 0; extra = 0; c = 0; prev = 1'b0;
    while (extra < 4 && c < 4000) begin
      @(negedge Clk);
      c++;
      check({name, ":mvalid"}, int'(bus.MoveValid), int'(prev && (idx < ref_path.size())));
      if (bus.MoveValid && idx < ref_path.size()) begin
        check({name, ":move"}, int'(bus.Move), ref_path[idx]);
        idx++;
      end
      if (idx >= ref_path.size()) extra++;
      r = ($urandom_range(0, 3) != 0);
      bus.Run = r;
      prev = r;
    end
    bus.Run = 1'b0;
    check({name, ":replay_len"}, idx, ref_path.size());
    check({name, ":done_hold"}, int'(bus.Done), 1);
  endtask

  // mode 0: replay after success; mode 1: Start+Run together in DONE.
  task automatic run_search(input string name, input int noise, input int mode, output int n);
    bit seen;
    int wr_snap;
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    model_run();
    bus.Start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4000) begin
      @(negedge Clk);
      n++;
      seen = bus.Done || bus.Fail;
      if (noise != 0 && n >= noise && n < noise + 3) bus.Start = 1'b1;
      else bus.Start = 1'b0;
    end
    check({name, ":cycles"}, n, ref_cycles);
    check({name, ":done"}, int'(bus.Done), int'(ref_ok));
    check({name, ":fail"}, int'(bus.Fail), int'(!ref_ok));
    check({name, ":wr_count"}, wr_cnt, ref_wr.size());
    for (int i = 0; i < ref_wr.size() && i < wr_cnt && i < 1024; i++)
      check({name, ":wr_addr"}, wr_addr[i], ref_wr[i]);
    check({name, ":din"}, din_bad, 0);
    if (ref_ok && mode == 0) replay(name);
    if (ref_ok && mode == 1) begin
      wr_snap = wr_cnt;
      bus.Start = 1'b1;
      bus.Run   = 1'b1;
      @(negedge Clk);
      check({name, ":sr_mvalid"}, int'(bus.MoveValid), 0);
      check({name, ":sr_done"}, int'(bus.Done), 0);
      bus.Start = 1'b0;
      bus.Run   = 1'b0;
      @(negedge Clk);
      // Memory is never restored, so (0,0) is already marked.
      check({name, ":rerun_fail"}, int'(bus.Fail), 1);
      check({name, ":rerun_mvalid"}, int'(bus.MoveValid), 0);
      check({name, ":rerun_wr"}, wr_cnt, wr_snap);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        img[i][j] = 1'b0;
  endtask

  int n;

  initial begin
    our_reset = 1'b0;
    bus.Start = 1'b0;
    bus.Run   = 1'b0;
    load      = 1'b0;
    clear_img();
    #1;
    check("reset_outputs",
          int'({bus.X, bus.Y, bus.Rd, bus.Wr, bus.Din, bus.Done, bus.Fail, bus.Move, bus.MoveValid}), 0);
    @(negedge Clk);
    our_reset = 1'b1;

    // All free, with Start pulsed mid-search (must be ignored).
    clear_img();
    run_search("free", 10, 0, n);
    check("free:done_at_47", n, 47);

    // All free again, then Start+Run together in DONE.
    clear_img();
    run_search("start_run", 0, 1, n);

    // Wall at the origin.
    clear_img();
    img[0][0] = 1'b1;
    run_search("wall_origin", 0, 0, n);

    // Boxed in at the origin.
    clear_img();
    img[0][1] = 1'b1;
    img[1][0] = 1'b1;
    run_search("boxed", 0, 0, n);

    // Dead-end corridor up column 0.
    clear_img();
    img[0][3] = 1'b1;
    img[1][1] = 1'b1;
    img[1][2] = 1'b1;
    run_search("dead_end", 0, 0, n);

    // Asynchronous reset in the middle of PROBE.
    clear_img();
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("rst_pre_rd", int'(bus.Rd), 1);
    #2 our_reset = 1'b0;
    #1;
    check("rst_async_outputs",
          int'({bus.X, bus.Y, bus.Rd, bus.Wr, bus.Din, bus.Done, bus.Fail, bus.Move, bus.MoveValid}), 0);
    @(negedge Clk);
    our_reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_idle", int'({bus.X, bus.Y, bus.Rd, bus.Wr, bus.Done, bus.Fail}), 0);
    run_search("after_reset", 0, 0, n);

    // Random mazes.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          img[i][j] = ($urandom_range(0, 99) < 30);
      img[0][0] = ($urandom_range(0, 19) == 0);
      run_search($sformatf("rand%0d", t), 0, 0, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
